fifo_stream_arbiter: RTL and testbench

Round-robin arbiter that merges up to 8 independent 32-bit first-word-fall-through FIFO sources into the single FIFO_EMPTY/FIFO_DATA/FIFO_READ_NEXT stream consumed by the SRAM FIFO core. Each grant is held for a bus-configurable burst of words, and channels can be masked individually. A saturating transferred-word counter is readable over the 8-bit basil bus. It sits between the readout channel FIFOs and the SRAM FIFO input, behind its own bus address window.

---
 rtl/fifo_stream_arbiter.sv | 128 ++++++++++++
 tb/tb_fifo_stream_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_arbiter.sv
// Round-robin merge of CHANNELS FWFT sources into one FWFT stream with burst-limited grants and bus registers.
// Zero added latency (data/empty/pops combinational); FIFO_READ_NEXT low holds the grant and burst count.
module fifo_stream_arbiter #(
  parameter int CHANNELS = 4
) (
  input  logic                    BUS_CLK,
  input  logic                    BUS_RST,
  input  logic [15:0]             BUS_ADD,
  input  logic [7:0]              BUS_DATA_IN,
  input  logic                    BUS_RD,
  input  logic                    BUS_WR,
  output logic [7:0]              BUS_DATA_OUT,
  input  logic [CHANNELS-1:0]     IN_FIFO_EMPTY,
  input  logic [32*CHANNELS-1:0]  IN_FIFO_DATA,
  output logic [CHANNELS-1:0]     IN_FIFO_READ,
  input  logic                    FIFO_READ_NEXT,
  output logic                    FIFO_EMPTY,
  output logic [31:0]             FIFO_DATA,
  output logic [CHANNELS-1:0]     GRANT
);
  localparam logic [7:0] VERSION = 8'd1;
  localparam int GW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int CW = GW + 1;
  localparam logic [CW-1:0] NCH = CW'(CHANNELS);
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  logic                rst;
  logic [0:0]          state;
  logic [GW-1:0]       grant, last, next_grant;
  logic [7:0]          burst, burst_cnt, burst_cnt_inc, rd_data;
  logic [CHANNELS-1:0] mask;
  logic [31:0]         word_count, count_buf;
  logic [31:0]         src_data [CHANNELS];
  logic                granted, src_empty, xfer, grant_done, found, count_inc;
  logic [CW-1:0]       cand;

  assign rst = BUS_RST | (BUS_WR && BUS_ADD == 16'd0);

  for (genvar k = 0; k < CHANNELS; k++) begin : g_src
    assign src_data[k] = IN_FIFO_DATA[32*k +: 32];
  end

  // Empty is forced high during reset so a word shown downstream is never silently dropped
  assign granted       = (state == ST_GRANT);
  assign src_empty     = IN_FIFO_EMPTY[grant];
  assign FIFO_EMPTY    = !granted || src_empty || rst;
  assign FIFO_DATA     = granted ? src_data[grant] : 32'd0;
  assign xfer          = FIFO_READ_NEXT && !FIFO_EMPTY;
  assign burst_cnt_inc = burst_cnt + 8'd1;
  assign count_inc     = xfer && (word_count != 32'hFFFF_FFFF);
  assign grant_done    = src_empty || !mask[grant] ||
                         (xfer && burst != 8'd0 && burst_cnt_inc == burst);

  always_comb begin
    GRANT        = '0;
    IN_FIFO_READ = '0;
    if (granted) begin
      GRANT[grant]        = 1'b1;
      IN_FIFO_READ[grant] = xfer;
    end
  end

  // Cyclic search starting one past the last served channel
  always_comb begin
    found      = 1'b0;
    next_grant = '0;
    cand       = '0;
    for (int k = 1; k <= CHANNELS; k++) begin
      cand = {1'b0, last} + CW'(k);
      if (cand >= NCH) cand = cand - NCH;
      if (!found && mask[cand[GW-1:0]] && !IN_FIFO_EMPTY[cand[GW-1:0]]) begin
        found      = 1'b1;
        next_grant = cand[GW-1:0];
      end
    end
  end

  always_comb begin
    rd_data = 8'd0;
    case (BUS_ADD)
      16'd0:   rd_data = VERSION;
      16'd1:   rd_data = 8'(mask);
      16'd2:   rd_data = burst;
      16'd3:   rd_data = {state, 4'b0000, 3'(grant)};
      16'd4:   rd_data = word_count[7:0];
      16'd5:   rd_data = count_buf[15:8];
      16'd6:   rd_data = count_buf[23:16];
      16'd7:   rd_data = count_buf[31:24];
      default: rd_data = 8'd0;
    endcase
  end

  always_ff @(posedge BUS_CLK) begin
    if (rst) begin
      state        <= ST_IDLE;
      grant        <= '0;
      last         <= GW'(CHANNELS - 1);
      burst_cnt    <= 8'd0;
      burst        <= 8'd16;
      mask         <= '1;
      word_count   <= 32'd0;
      count_buf    <= 32'd0;
      BUS_DATA_OUT <= 8'd0;
    end else begin
      if (BUS_RD) begin
        BUS_DATA_OUT <= rd_data;
        if (BUS_ADD == 16'd4) count_buf <= word_count;
      end
      if (BUS_WR && BUS_ADD == 16'd1) mask  <= BUS_DATA_IN[CHANNELS-1:0];
      if (BUS_WR && BUS_ADD == 16'd2) burst <= BUS_DATA_IN;
      word_count <= word_count + {31'd0, count_inc};
      if (state == ST_IDLE) begin
        if (found) begin
          state     <= ST_GRANT;
          grant     <= next_grant;
          burst_cnt <= 8'd0;
        end
      end else begin
        if (xfer) burst_cnt <= burst_cnt_inc;
        if (grant_done) begin
          state <= ST_IDLE;
          last  <= grant;
        end
      end
    end
  end
endmodule

// File: tb/tb_fifo_stream_arbiter.sv
// Bench for fifo_stream_arbiter: queue-backed source FIFOs, transaction-level reference model, scoreboard monitor.
module tb_fifo_stream_arbiter;
  localparam int CH    = 4;
  localparam int DEPTH = 1024;

  logic BUS_CLK = 1'b0;
  always #5 BUS_CLK = ~BUS_CLK;

  logic              BUS_RST = 1'b1;
  logic [15:0]       BUS_ADD = '0;
  logic [7:0]        BUS_DATA_IN = '0;
  logic              BUS_RD = 1'b0;
  logic              BUS_WR = 1'b0;
  logic [7:0]        BUS_DATA_OUT;
  logic [CH-1:0]     IN_FIFO_EMPTY = '1;
  logic [32*CH-1:0]  IN_FIFO_DATA = '0;
  logic [CH-1:0]     IN_FIFO_READ;
  logic              FIFO_READ_NEXT = 1'b0;
  logic              FIFO_EMPTY;
  logic [31:0]       FIFO_DATA;
  logic [CH-1:0]     GRANT;

  fifo_stream_arbiter #(.CHANNELS(CH)) dut (
    .BUS_CLK(BUS_CLK), .BUS_RST(BUS_RST), .BUS_ADD(BUS_ADD), .BUS_DATA_IN(BUS_DATA_IN),
    .BUS_RD(BUS_RD), .BUS_WR(BUS_WR), .BUS_DATA_OUT(BUS_DATA_OUT),
    .IN_FIFO_EMPTY(IN_FIFO_EMPTY), .IN_FIFO_DATA(IN_FIFO_DATA), .IN_FIFO_READ(IN_FIFO_READ),
    .FIFO_READ_NEXT(FIFO_READ_NEXT), .FIFO_EMPTY(FIFO_EMPTY), .FIFO_DATA(FIFO_DATA), .GRANT(GRANT)
  );

  typedef struct packed {
    logic [CH-1:0] grant;
    logic [CH-1:0] rd;
    logic          empty;
    logic [31:0]   data;
    logic [7:0]    dout;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int n_checks = 0;
  int n_errors = 0;

  // Source FIFO storage
  logic [31:0] mem [CH][DEPTH];
  int rp [CH];
  int wp [CH];
  int seq = 1;
  logic [CH-1:0] rd_prev = '0;

  // Stimulus for the next cycle
  bit s_rst = 1'b1, s_rn = 1'b0, s_wr = 1'b0, s_rd = 1'b0;
  logic [15:0] s_add = '0;
  logic [7:0]  s_din = '0;

  // Reference model state
  bit          m_busy = 1'b0;
  int          m_g = 0, m_last = CH - 1, m_bcnt = 0, m_burst = 16;
  logic [CH-1:0] m_mask = '1;
  logic [31:0] m_wc = '0, m_buf = '0;
  logic [7:0]  m_dout = '0;

  function automatic int occ(int c);
    return wp[c] - rp[c];
  endfunction

  function automatic logic [31:0] head(int c);
    return (occ(c) == 0) ? 32'd0 : mem[c][rp[c] % DEPTH];
  endfunction

  task automatic push_words(int c, int n);
    for (int i = 0; i < n; i++) begin
      mem[c][wp[c] % DEPTH] = (32'(c) << 28) | 32'(seq);
      seq++;
      wp[c]++;
    end
  endtask

  function automatic logic [7:0] read_val(logic [15:0] a);
    logic [2:0] gi;
    gi = 3'(m_g);
    case (a)
      16'd0:   return 8'd1;
      16'd1:   return 8'(m_mask);
      16'd2:   return 8'(m_burst);
      16'd3:   return {m_busy, 4'b0000, gi};
      16'd4:   return m_wc[7:0];
      16'd5:   return m_buf[15:8];
      16'd6:   return m_buf[23:16];
      16'd7:   return m_buf[31:24];
      default: return 8'd0;
    endcase
  endfunction

  task automatic model_cycle();
    bit rst, sempty, xfer, hit;
    exp_t x;
    int c;
    rst    = s_rst || (s_wr && s_add == 16'd0);
    sempty = (occ(m_g) == 0);
    x.grant = m_busy ? (CH'(1) << m_g) : '0;
    x.empty = !m_busy || sempty || rst;
    x.data  = m_busy ? head(m_g) : 32'd0;
    x.rd    = (m_busy && s_rn && !sempty && !rst) ? (CH'(1) << m_g) : '0;
    x.dout  = m_dout;
    exp_q.push_back(x);
    xfer = s_rn && !x.empty;
    if (rst) begin
      m_busy = 0; m_g = 0; m_last = CH - 1; m_bcnt = 0; m_burst = 16;
      m_mask = '1; m_wc = '0; m_buf = '0; m_dout = '0;
    end else begin
      if (s_rd) begin
        m_dout = read_val(s_add);
        if (s_add == 16'd4) m_buf = m_wc;
      end
      if (m_busy) begin
        if (xfer) begin
          m_bcnt = (m_bcnt + 1) % 256;
          if (m_wc != 32'hFFFF_FFFF) m_wc = m_wc + 1;
        end
        if ((xfer && m_burst != 0 && m_bcnt == m_burst) || sempty || !m_mask[m_g]) begin
          m_busy = 0;
          m_last = m_g;
        end
      end else begin
        hit = 0;
        for (int k = 1; k <= CH; k++) begin
          c = (m_last + k) % CH;
          if (!hit && m_mask[c] && occ(c) > 0) begin
            hit = 1; m_busy = 1; m_g = c; m_bcnt = 0;
          end
        end
      end
      if (s_wr && s_add == 16'd1) m_mask = s_din[CH-1:0];
      if (s_wr && s_add == 16'd2) m_burst = int'(s_din);
    end
  endtask

  task automatic step();
    @(posedge BUS_CLK);
    #1;
    for (int c = 0; c < CH; c++)
      if (rd_prev[c] && occ(c) > 0) rp[c]++;
    BUS_RST = s_rst; BUS_WR = s_wr; BUS_RD = s_rd; BUS_ADD = s_add; BUS_DATA_IN = s_din;
    FIFO_READ_NEXT = s_rn;
    for (int c = 0; c < CH; c++) begin
      IN_FIFO_EMPTY[c] = (occ(c) == 0);
      IN_FIFO_DATA[32*c +: 32] = head(c);
    end
    #1;
    model_cycle();
    s_wr = 1'b0;
    s_rd = 1'b0;
    #1;
    rd_prev = IN_FIFO_READ;
  endtask

  task automatic run(int n);
    repeat (n) step();
  endtask

  task automatic bus_wr(logic [15:0] a, logic [7:0] d);
    s_wr = 1'b1; s_add = a; s_din = d;
    step();
  endtask

  task automatic bus_rd(logic [15:0] a);
    s_rd = 1'b1; s_add = a;
    step();
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: actual %h required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(negedge BUS_CLK) begin
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("grant",        32'(GRANT),        32'(e.grant));
      chk("in_fifo_read", 32'(IN_FIFO_READ), 32'(e.rd));
      chk("fifo_empty",   32'(FIFO_EMPTY),   32'(e.empty));
      chk("fifo_data",    FIFO_DATA,         e.data);
      chk("bus_data_out", 32'(BUS_DATA_OUT), 32'(e.dout));
    end
  end

  initial begin
    for (int c = 0; c < CH; c++) begin rp[c] = 0; wp[c] = 0; end
    s_rst = 1'b1;
    run(3);
    s_rst = 1'b0;
    bus_rd(16'd0); bus_rd(16'd1); bus_rd(16'd2); bus_rd(16'd3);

    // Round-robin across all channels, 40 words each, burst 16
    for (int c = 0; c < CH; c++) push_words(c, 40);
    s_rn = 1'b1;
    run(180);
    s_rn = 1'b0;
    bus_rd(16'd4); bus_rd(16'd5); bus_rd(16'd6); bus_rd(16'd7);

    // Empty exit and cyclic wrap
    push_words(2, 1);
    s_rn = 1'b1;
    run(4);
    push_words(3, 3);
    run(8);
    push_words(0, 2);
    run(6);
    bus_rd(16'd3);

    // Mask written during a grant of channel 1
    for (int c = 0; c < CH; c++) push_words(c, 20);
    run(3);
    bus_wr(16'd1, 8'h05);
    run(60);
    bus_rd(16'd1);
    bus_wr(16'd1, 8'h0F);
    run(40);

    // Randomised traffic, masks, bursts and reads
    for (int i = 0; i < 1500; i++) begin
      int c;
      s_rn = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) begin
        c = int'($urandom_range(0, CH - 1));
        if (occ(c) < 200) push_words(c, int'($urandom_range(1, 4)));
      end
      if ($urandom_range(0, 9) == 0) begin
        case ($urandom_range(0, 2))
          0: begin s_wr = 1'b1; s_add = 16'd1; s_din = 8'($urandom_range(1, 15)); end
          1: begin s_wr = 1'b1; s_add = 16'd2; s_din = 8'($urandom_range(0, 6)); end
          default: begin s_rd = 1'b1; s_add = 16'($urandom_range(1, 8)); end
        endcase
      end
      step();
    end

    // Drain, then unlimited burst on channel 2 with toggling backpressure
    bus_wr(16'd1, 8'h0F);
    bus_wr(16'd2, 8'd16);
    s_rn = 1'b1;
    run(1200);
    bus_wr(16'd2, 8'd0);
    push_words(2, 300);
    for (int i = 0; i < 640; i++) begin
      s_rn = i[0];
      step();
    end
    bus_rd(16'd3);

    // Word counter saturation
    s_rn = 1'b0;
    bus_wr(16'd2, 8'd16);
    step();
    force dut.word_count = 32'hFFFF_FFFE;
    m_wc = 32'hFFFF_FFFE;
    run(2);
    release dut.word_count;
    push_words(0, 3);
    s_rn = 1'b1;
    run(6);
    s_rn = 1'b0;
    bus_rd(16'd4); bus_rd(16'd5); bus_rd(16'd6); bus_rd(16'd7);

    // Soft reset in the middle of a channel 1 burst
    push_words(1, 10);
    push_words(3, 5);
    s_rn = 1'b1;
    run(4);
    bus_wr(16'd0, 8'd0);
    s_rn = 1'b0;
    bus_rd(16'd4);
    s_rn = 1'b1;
    run(30);
    s_rn = 1'b0;
    bus_rd(16'd4);
    s_rn = 1'b1;
    run(40);

    @(negedge BUS_CLK);
    #1;
    chk("leftover_expectations", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
